id_fetch_receiver: RTL and testbench
====================================

// Module: id_fetch_receiver
// PURPOSE
//  ID-side receiver of the fetch interface. Registers the IF stage's After_pc/inst pair in the IF/ID register.
//  Resolves beq/bne/j in ID and returns PCSrc/target to the IF stage's PC mux.
//  Squashes wrong-path fetches with bubbles, holds on hazard stall, and keeps saturating redirect/bubble counters.
// PARAMETERS
//  FLUSH_CYCLES  1   bubbles inserted per redirect (1..3); set to 2 when the instruction memory read is registered
//  CNT_W         16  width of the performance counters
// PORTS
//  clk           in   1      clock; all state updates on the rising edge
//  rst           in   1      synchronous, active-high reset
//  if_pc_plus4   in   32     After_pc from the IF stage (fetch PC + 4)
//  if_inst       in   32     inst from the IF stage
//  stall         in   1      hazard unit: hold the IF/ID register
//  rs_data       in   32     register-file read of id_inst[25:21]
//  rt_data       in   32     register-file read of id_inst[20:16]
//  id_pc_plus4   out  32     registered PC+4 of the instruction in ID
//  id_inst       out  32     registered instruction; 32'h0 (NOP) when it is a bubble
//  id_valid      out  1      id_inst is a real instruction
//  pcsrc         out  1      to the IF stage's PCSrc: select target (combinational)
//  target        out  32     redirect address (combinational)
//  redirect_cnt  out  CNT_W  number of redirects taken, saturating
//  bubble_cnt    out  CNT_W  number of bubbles inserted, saturating
// BEHAVIOUR
//  Reset: id_pc_plus4=0, id_inst=0, id_valid=0, state=RUN, flush counter=0, redirect_cnt=0, bubble_cnt=0.
//    pcsrc=0 and target=0 combinationally while id_valid=0.
//  Decode (from id_inst, qualified by id_valid && state==RUN && !stall):
//    beq op=6'b000100: taken when rs_data==rt_data
//    bne op=6'b000101: taken when rs_data!=rt_data
//    j   op=6'b000010: always taken
//    Any other opcode is never taken.
//  Target arithmetic, 32-bit modulo with no overflow flag:
//    branch: id_pc_plus4 + {{14{imm[15]}},imm,2'b00}
//    j:      {id_pc_plus4[31:28], id_inst[25:0], 2'b00}
//  pcsrc = taken. target holds the computed address whenever id_valid=1, even when not taken.
//  FSM states: RUN, FLUSH.
//  RUN, rising edge:
//    stall=1: hold every ID register; pcsrc is forced to 0, so a branch waits for its operands.
//    taken (implies stall=0): load id_inst=0, id_valid=0, id_pc_plus4=if_pc_plus4; redirect_cnt+=1; bubble_cnt+=1.
//      If FLUSH_CYCLES>1: go to FLUSH with counter=FLUSH_CYCLES-2.
//    Otherwise: load id_inst=if_inst, id_pc_plus4=if_pc_plus4, id_valid=1.
//  FLUSH, rising edge:
//    Insert a bubble (id_inst=0, id_valid=0); bubble_cnt+=1; pcsrc=0; stall is ignored.
//    counter==0: next state RUN, else counter-=1.
//  Latency: the instruction presented at edge N is in ID after edge N.
//    A taken branch drives pcsrc in the same cycle; the IF stage loads target at the next edge.
//  Simultaneous events: stall outranks branch resolution; rst outranks everything, including mid-FLUSH.
//  Counters saturate at all-ones and never wrap.
// TESTING
//  T1 rst=1 for 2 clk -> all outputs 0, state RUN; release with if_inst=32'h2008_0005 -> id_inst=32'h2008_0005, id_valid=1 next edge.
//  T2 beq $1,$2,+4 at id_pc_plus4=32'h0000_0010, rs=rt=7 -> pcsrc=1, target=32'h0000_0020; next edge id_inst=0, id_valid=0, redirect_cnt=1.
//  T3 same beq with rs=7, rt=8 -> pcsrc=0; next fetched instruction is accepted normally; bubble_cnt stays 0.
//  T4 j 26'h000_0040 at id_pc_plus4=32'h4000_0008 -> target=32'h4000_0100; with FLUSH_CYCLES=2 exactly 2 bubbles, bubble_cnt=2.
//  T5 bne taken with stall=1 held 3 cycles -> pcsrc=0 and ID held; stall drops -> pcsrc=1 in that cycle.
//  T6 rst asserted in FLUSH -> RUN and all zero next edge; drive 2^CNT_W+3 redirects -> redirect_cnt saturates at all-ones.

Source files
------------

// File: rtl/id_fetch_receiver.sv
// ID-side receiver of the fetch interface: IF/ID register, beq/bne/j resolution
// in ID, wrong-path squashing with bubbles, and saturating redirect/bubble counters.
module id_fetch_receiver #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc_plus4,
    input  logic [31:0]      if_inst,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             pcsrc,
    output logic [31:0]      target,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    // The first bubble is loaded by the redirect itself; FLUSH supplies the rest.
    localparam logic [1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 32'd1) ? 2'(FLUSH_CYCLES - 32'd2) : 2'd0;
    localparam logic       USE_FLUSH  = (FLUSH_CYCLES > 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        flush_cnt_r;
    logic [1:0]        flush_cnt_nxt_s;
    logic [31:0]       id_pc_plus4_r;
    logic [31:0]       id_pc_plus4_nxt_s;
    logic [31:0]       id_inst_r;
    logic [31:0]       id_inst_nxt_s;
    logic              id_valid_r;
    logic              id_valid_nxt_s;
    logic [CNT_W-1:0]  redirect_cnt_r;
    logic [CNT_W-1:0]  redirect_cnt_nxt_s;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_nxt_s;

    logic [5:0]        opcode_s;
    logic              is_beq_s;
    logic              is_bne_s;
    logic              is_j_s;
    logic              operands_eq_s;
    logic              cond_s;
    logic              taken_s;
    logic [31:0]       branch_off_s;
    logic [31:0]       branch_tgt_s;
    logic [31:0]       jump_tgt_s;
    logic [31:0]       target_s;

    assign opcode_s      = id_inst_r[31:26];
    assign is_beq_s      = (opcode_s == OP_BEQ);
    assign is_bne_s      = (opcode_s == OP_BNE);
    assign is_j_s        = (opcode_s == OP_J);
    assign operands_eq_s = (rs_data == rt_data);
    assign branch_off_s  = {{14{id_inst_r[15]}}, id_inst_r[15:0], 2'b00};
    assign branch_tgt_s  = id_pc_plus4_r + branch_off_s;
    assign jump_tgt_s    = {id_pc_plus4_r[31:28], id_inst_r[25:0], 2'b00};

    // Branch resolution: a stall or a flush suppresses the redirect.
    always_comb begin
        cond_s  = 1'b0;
        taken_s = 1'b0;
        if (is_j_s) begin
            cond_s = 1'b1;
        end else if (is_beq_s) begin
            cond_s = operands_eq_s;
        end else if (is_bne_s) begin
            cond_s = ~operands_eq_s;
        end else begin
            cond_s = 1'b0;
        end
        if (id_valid_r && (state_r == RUN) && !stall) begin
            taken_s = cond_s;
        end else begin
            taken_s = 1'b0;
        end
    end

    // Redirect address, computed even when the branch falls through.
    always_comb begin
        target_s = 32'h0000_0000;
        if (!id_valid_r) begin
            target_s = 32'h0000_0000;
        end else if (is_j_s) begin
            target_s = jump_tgt_s;
        end else begin
            target_s = branch_tgt_s;
        end
    end

    // Next-state and IF/ID register update.
    always_comb begin
        state_nxt_s        = state_r;
        flush_cnt_nxt_s    = flush_cnt_r;
        id_pc_plus4_nxt_s  = id_pc_plus4_r;
        id_inst_nxt_s      = id_inst_r;
        id_valid_nxt_s     = id_valid_r;
        redirect_cnt_nxt_s = redirect_cnt_r;
        bubble_cnt_nxt_s   = bubble_cnt_r;
        case (state_r)
            RUN: begin
                if (stall) begin
                    id_pc_plus4_nxt_s = id_pc_plus4_r;
                    id_inst_nxt_s     = id_inst_r;
                    id_valid_nxt_s    = id_valid_r;
                end else if (taken_s) begin
                    id_pc_plus4_nxt_s  = if_pc_plus4;
                    id_inst_nxt_s      = 32'h0000_0000;
                    id_valid_nxt_s     = 1'b0;
                    redirect_cnt_nxt_s = sat_inc(redirect_cnt_r);
                    bubble_cnt_nxt_s   = sat_inc(bubble_cnt_r);
                    if (USE_FLUSH) begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = FLUSH_LOAD;
                    end else begin
                        state_nxt_s     = RUN;
                        flush_cnt_nxt_s = 2'd0;
                    end
                end else begin
                    id_pc_plus4_nxt_s = if_pc_plus4;
                    id_inst_nxt_s     = if_inst;
                    id_valid_nxt_s    = 1'b1;
                end
            end
            FLUSH: begin
                id_pc_plus4_nxt_s = if_pc_plus4;
                id_inst_nxt_s     = 32'h0000_0000;
                id_valid_nxt_s    = 1'b0;
                bubble_cnt_nxt_s  = sat_inc(bubble_cnt_r);
                if (flush_cnt_r == 2'd0) begin
                    state_nxt_s = RUN;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s     = RUN;
                flush_cnt_nxt_s = 2'd0;
                id_inst_nxt_s   = 32'h0000_0000;
                id_valid_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RUN;
            flush_cnt_r    <= 2'd0;
            id_pc_plus4_r  <= 32'h0000_0000;
            id_inst_r      <= 32'h0000_0000;
            id_valid_r     <= 1'b0;
            redirect_cnt_r <= '0;
            bubble_cnt_r   <= '0;
        end else begin
            state_r        <= state_nxt_s;
            flush_cnt_r    <= flush_cnt_nxt_s;
            id_pc_plus4_r  <= id_pc_plus4_nxt_s;
            id_inst_r      <= id_inst_nxt_s;
            id_valid_r     <= id_valid_nxt_s;
            redirect_cnt_r <= redirect_cnt_nxt_s;
            bubble_cnt_r   <= bubble_cnt_nxt_s;
        end
    end

    assign id_pc_plus4  = id_pc_plus4_r;
    assign id_inst      = id_inst_r;
    assign id_valid     = id_valid_r;
    assign redirect_cnt = redirect_cnt_r;
    assign bubble_cnt   = bubble_cnt_r;
    assign pcsrc        = taken_s;
    assign target       = target_s;

endmodule

// File: tb/tb_id_fetch_receiver.sv
// Bench for id_fetch_receiver: two instances (single- and double-bubble flush)
// share stimulus; directed vectors plus random cycles against a reference model.
module tb_id_fetch_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [31:0] a_pc, a_inst, a_tgt, b_pc, b_inst, b_tgt;
    logic        a_valid, a_pcsrc, b_valid, b_pcsrc;
    logic [15:0] a_rc, a_bc;
    logic [3:0]  b_rc, b_bc;

    always #5 clk = ~clk;

    id_fetch_receiver #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst),
        .stall(stall), .rs_data(rs_data), .rt_data(rt_data),
        .id_pc_plus4(a_pc), .id_inst(a_inst), .id_valid(a_valid),
        .pcsrc(a_pcsrc), .target(a_tgt), .redirect_cnt(a_rc), .bubble_cnt(a_bc)
    );

    id_fetch_receiver #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst),
        .stall(stall), .rs_data(rs_data), .rt_data(rt_data),
        .id_pc_plus4(b_pc), .id_inst(b_inst), .id_valid(b_valid),
        .pcsrc(b_pcsrc), .target(b_tgt), .redirect_cnt(b_rc), .bubble_cnt(b_bc)
    );

    logic [31:0] o_pc[2], o_inst[2], o_tgt[2], o_rc[2], o_bc[2];
    logic        o_valid[2], o_pcsrc[2];
    assign o_pc[0] = a_pc;    assign o_pc[1] = b_pc;
    assign o_inst[0] = a_inst; assign o_inst[1] = b_inst;
    assign o_tgt[0] = a_tgt;  assign o_tgt[1] = b_tgt;
    assign o_rc[0] = {16'h0, a_rc}; assign o_rc[1] = {28'h0, b_rc};
    assign o_bc[0] = {16'h0, a_bc}; assign o_bc[1] = {28'h0, b_bc};
    assign o_valid[0] = a_valid; assign o_valid[1] = b_valid;
    assign o_pcsrc[0] = a_pcsrc; assign o_pcsrc[1] = b_pcsrc;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Reference model: ID contents plus number of bubbles still owed.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        int          left;
        int          rc;
        int          bc;
    } m_t;
    m_t m[2];

    function automatic int bubbles_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int sat(int c, int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic m_taken(m_t s, logic st, logic [31:0] rs, logic [31:0] rt);
        logic [5:0] op;
        op = s.inst[31:26];
        if (!s.valid || s.left > 0 || st) return 1'b0;
        if (op == 6'd2) return 1'b1;
        if (op == 6'd4) return rs == rt;
        if (op == 6'd5) return rs != rt;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_target(m_t s);
        logic [31:0] off;
        if (!s.valid) return 32'h0;
        if (s.inst[31:26] == 6'd2) return {s.pc[31:28], s.inst[25:0], 2'b00};
        off = {{16{s.inst[15]}}, s.inst[15:0]};
        return s.pc + off * 32'd4;
    endfunction

    function automatic m_t m_next(int k, m_t s);
        m_t n;
        n = s;
        if (rst) begin
            n.pc = 32'h0; n.inst = 32'h0; n.valid = 1'b0;
            n.left = 0; n.rc = 0; n.bc = 0;
        end else if (s.left > 0) begin
            n.inst = 32'h0; n.valid = 1'b0; n.pc = if_pc_plus4;
            n.bc = s.bc + 1; n.left = s.left - 1;
        end else if (stall) begin
            n = s;
        end else if (m_taken(s, stall, rs_data, rt_data)) begin
            n.inst = 32'h0; n.valid = 1'b0; n.pc = if_pc_plus4;
            n.rc = s.rc + 1; n.bc = s.bc + 1; n.left = bubbles_of(k) - 1;
        end else begin
            n.inst = if_inst; n.valid = 1'b1; n.pc = if_pc_plus4;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Combinational outputs, sampled mid-cycle.
    task automatic pre();
        @(negedge clk);
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m_pcsrc%0d", k), 32'(o_pcsrc[k]),
                    32'(m_taken(m[k], stall, rs_data, rt_data)));
                chk($sformatf("m_target%0d", k), o_tgt[k], m_target(m[k]));
            end
        end
    endtask

    // Clock edge, model update, registered outputs sampled after the edge.
    task automatic post();
        @(posedge clk);
        if (rst) model_on = 1'b1;
        if (model_on) begin
            for (int k = 0; k < 2; k++) m[k] = m_next(k, m[k]);
        end
        #1;
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m_inst%0d", k), o_inst[k], m[k].inst);
                chk($sformatf("m_valid%0d", k), 32'(o_valid[k]), 32'(m[k].valid));
                chk($sformatf("m_rc%0d", k), o_rc[k], 32'(sat(m[k].rc, cmax_of(k))));
                chk($sformatf("m_bc%0d", k), o_bc[k], 32'(sat(m[k].bc, cmax_of(k))));
                if (m[k].valid) chk($sformatf("m_pc%0d", k), o_pc[k], m[k].pc);
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        stall;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        chk_comb;
        logic        pcsrc;
        logic [31:0] tgt;
        logic [31:0] e_inst;
        logic        e_valid;
        int          e_rc;
        int          e_bc;
    } vec_t;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic [31:0] inst, logic st,
                                logic [31:0] rs, logic [31:0] rt, logic cc, logic ps,
                                logic [31:0] tg, logic [31:0] ei, logic ev, int erc, int ebc);
        vec_t v;
        v.rst = r; v.pc = pc; v.inst = inst; v.stall = st; v.rs = rs; v.rt = rt;
        v.chk_comb = cc; v.pcsrc = ps; v.tgt = tg; v.e_inst = ei; v.e_valid = ev;
        v.e_rc = erc; v.e_bc = ebc;
        return v;
    endfunction

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] ADDI2 = 32'h2009_0007;
    localparam logic [31:0] BEQ  = 32'h1022_0004;
    localparam logic [31:0] BNE  = 32'h1422_0004;
    localparam logic [31:0] JMP  = 32'h0800_0040;
    localparam logic [31:0] SW   = 32'hAC01_0008;

    vec_t tbl[19];

    initial begin
        // Directed vectors for the single-bubble instance (dut_a).
        tbl[0]  = mk(1, 32'h00, 32'h0, 0, 0, 0, 0, 0, 32'h00,  32'h0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h00, 32'h0, 0, 0, 0, 1, 0, 32'h00,  32'h0, 0, 0, 0);
        tbl[2]  = mk(0, 32'h04, ADDI,  0, 0, 0, 1, 0, 32'h00,  ADDI,  1, 0, 0);
        tbl[3]  = mk(0, 32'h10, BEQ,   0, 7, 8, 1, 0, 32'h18,  BEQ,   1, 0, 0);
        tbl[4]  = mk(0, 32'h14, ADDI,  0, 7, 8, 1, 0, 32'h20,  ADDI,  1, 0, 0);
        tbl[5]  = mk(0, 32'h10, BEQ,   0, 7, 7, 1, 0, 32'h28,  BEQ,   1, 0, 0);
        tbl[6]  = mk(0, 32'h14, ADDI,  0, 7, 7, 1, 1, 32'h20,  32'h0, 0, 1, 1);
        tbl[7]  = mk(0, 32'h20, BNE,   0, 7, 7, 1, 0, 32'h00,  BNE,   1, 1, 1);
        tbl[8]  = mk(0, 32'h24, ADDI,  1, 1, 2, 1, 0, 32'h30,  BNE,   1, 1, 1);
        tbl[9]  = mk(0, 32'h24, ADDI,  1, 1, 2, 1, 0, 32'h30,  BNE,   1, 1, 1);
        tbl[10] = mk(0, 32'h24, ADDI,  1, 1, 2, 1, 0, 32'h30,  BNE,   1, 1, 1);
        tbl[11] = mk(0, 32'h24, ADDI,  0, 1, 2, 1, 1, 32'h30,  32'h0, 0, 2, 2);
        tbl[12] = mk(0, 32'h34, JMP,   0, 1, 2, 1, 0, 32'h00,  JMP,   1, 2, 2);
        tbl[13] = mk(0, 32'h38, ADDI,  1, 1, 2, 1, 0, 32'h100, JMP,   1, 2, 2);
        tbl[14] = mk(0, 32'h38, ADDI,  0, 1, 2, 1, 1, 32'h100, 32'h0, 0, 3, 3);
        tbl[15] = mk(0, 32'h3C, ADDI,  1, 1, 2, 1, 0, 32'h00,  32'h0, 0, 3, 3);
        tbl[16] = mk(0, 32'h40, SW,    0, 1, 2, 1, 0, 32'h00,  SW,    1, 3, 3);
        tbl[17] = mk(0, 32'h44, ADDI,  0, 1, 2, 1, 0, 32'h60,  ADDI,  1, 3, 3);
        tbl[18] = mk(1, 32'h48, ADDI,  0, 1, 2, 1, 0, 32'h58,  32'h0, 0, 0, 0);

        rst = 1'b1; stall = 1'b0; if_pc_plus4 = 32'h0; if_inst = 32'h0;
        rs_data = 32'h0; rt_data = 32'h0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; if_pc_plus4 = tbl[i].pc; if_inst = tbl[i].inst;
            stall = tbl[i].stall; rs_data = tbl[i].rs; rt_data = tbl[i].rt;
            pre();
            if (tbl[i].chk_comb) begin
                chk($sformatf("v%0d_pcsrc", i), 32'(a_pcsrc), 32'(tbl[i].pcsrc));
                chk($sformatf("v%0d_target", i), a_tgt, tbl[i].tgt);
            end
            post();
            chk($sformatf("v%0d_inst", i), a_inst, tbl[i].e_inst);
            chk($sformatf("v%0d_valid", i), 32'(a_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_rc", i), 32'(a_rc), 32'(tbl[i].e_rc));
            chk($sformatf("v%0d_bc", i), 32'(a_bc), 32'(tbl[i].e_bc));
            if (tbl[i].rst) begin
                chk($sformatf("v%0d_pc_rst", i), a_pc, 32'h0);
                chk($sformatf("v%0d_b_valid_rst", i), 32'(b_valid), 32'h0);
            end
        end

        // Jump with two-bubble flush on dut_b.
        rst = 1'b0; stall = 1'b0; if_pc_plus4 = 32'h4000_0008; if_inst = JMP;
        pre(); post();
        if_pc_plus4 = 32'h4000_000C; if_inst = ADDI;
        pre();
        chk("j_pcsrc", 32'(b_pcsrc), 32'h1);
        chk("j_target", b_tgt, 32'h4000_0100);
        post();
        chk("j_bubble1_valid", 32'(b_valid), 32'h0);
        chk("j_bubble1_bc", 32'(b_bc), 32'h1);
        if_pc_plus4 = 32'h4000_0100; if_inst = ADDI;
        pre();
        chk("j_flush_pcsrc", 32'(b_pcsrc), 32'h0);
        post();
        chk("j_bubble2_inst", b_inst, 32'h0);
        chk("j_bubble2_valid", 32'(b_valid), 32'h0);
        chk("j_bubble2_bc", 32'(b_bc), 32'h2);
        if_pc_plus4 = 32'h4000_0104; if_inst = ADDI2;
        pre(); post();
        chk("j_resume_valid", 32'(b_valid), 32'h1);
        chk("j_resume_inst", b_inst, ADDI2);
        chk("j_resume_bc", 32'(b_bc), 32'h2);

        // Reset while dut_b is mid-flush.
        if_inst = JMP; pre(); post();
        if_inst = ADDI; pre(); post();
        rst = 1'b1; pre(); post();
        chk("rstflush_valid", 32'(b_valid), 32'h0);
        chk("rstflush_inst", b_inst, 32'h0);
        chk("rstflush_pc", b_pc, 32'h0);
        chk("rstflush_rc", 32'(b_rc), 32'h0);
        chk("rstflush_bc", 32'(b_bc), 32'h0);
        rst = 1'b0; if_inst = ADDI2; pre(); post();
        chk("rstflush_run_valid", 32'(b_valid), 32'h1);
        chk("rstflush_run_inst", b_inst, ADDI2);

        // 2^4+3 redirects on the 4-bit counters of dut_b.
        if_pc_plus4 = 32'h0000_0100; if_inst = JMP;
        for (int n = 0; n < 58; n++) begin
            pre(); post();
        end
        chk("sat_rc", 32'(b_rc), 32'hF);
        chk("sat_bc", 32'(b_bc), 32'hF);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            int sel;
            r = $urandom;
            sel = $urandom_range(0, 4);
            rst = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 4) == 0);
            case (sel)
                0: if_inst = {6'b000100, r[25:0]};
                1: if_inst = {6'b000101, r[25:0]};
                2: if_inst = {6'b000010, r[25:0]};
                3: if_inst = {6'b001000, r[25:0]};
                default: if_inst = $urandom;
            endcase
            if_pc_plus4 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                rs_data = $urandom; rt_data = $urandom;
            end else begin
                rs_data = 32'($urandom_range(0, 2)); rt_data = 32'($urandom_range(0, 2));
            end
            pre(); post();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
